grid_cursor_ctrl: RTL
=====================

Name: grid_cursor_ctrl

Overview:
Parametrised cursor controller for the battleship board. It debounces the direction and fire buttons and moves a cursor over a GRID_COLS x GRID_ROWS grid, with clamp or wrap at the edges. It issues the selected cell on a valid/ready handshake to the game logic. It also flags the pixels inside the cursor cell so the renderer can draw the cursor.

Parameters:
GRID_COLS, 10, number of columns (2..16)
GRID_ROWS, 10, number of rows (2..16)
CELL_W, 64, cell width in pixels
CELL_H, 48, cell height in pixels
GRID_LEFT, 144, hCount of the grid's left edge
GRID_TOP, 35, vCount of the grid's top edge
LINE_THICK, 1, grid line inset excluded from the cursor rectangle
SAMPLE_DIV, 65536, clk cycles per sample tick
DEB_DEPTH, 3, consecutive equal samples needed to change a debounced level
WRAP, 0, 0 = clamp at edges, 1 = wrap to the opposite edge
REPEAT_DELAY, 24, held ticks before auto-repeat starts (macro only)
REPEAT_RATE, 6, ticks between auto-repeat steps (macro only)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
bright  in  1  active video area
hCount  in  10  current pixel x
vCount  in  10  current pixel y
btn_l, btn_r, btn_u, btn_d, btn_c  in  1 each  raw buttons (btn_c = fire)
enable  in  1  1 = player's turn; movement and fire accepted
sel_ready  in  1  game logic accepts the selection
sel_valid  out  1  selection pending
sel_row  out  RW=$clog2(GRID_ROWS)  selected row
sel_col  out  CW=$clog2(GRID_COLS)  selected column
cursor_row  out  RW  current row
cursor_col  out  CW  current column
in_cursor  out  1  pixel lies inside the cursor cell

Behaviour:
- Reset (rst_n=0 at posedge clk): sample counter, debounce histories, debounced levels, prev levels, cursor and selection registers all 0; sel_valid=0. Reset mid-handshake drops the pending selection.
- Sample tick: free-running counter modulo SAMPLE_DIV; tick is high for the one cycle where the counter equals 0. The first tick occurs in the first cycle after reset is released.
- Debounce, per button on each tick:
  - Shift the raw sample into a DEB_DEPTH-bit history.
  - Debounced level goes to 1 when the history is all ones and to 0 when it is all zeros; otherwise it holds (hysteresis).
  - Edge = debounced & ~prev, with prev registered on the tick.
- Movement, evaluated on a tick when enable=1 and sel_valid=0:
  - l and r edges together, or u and d edges together: no move on that axis.
  - Axes are independent, so diagonal moves are allowed.
  - Clamp mode: at column 0, l is ignored; at column GRID_COLS-1, r is ignored. Rows behave the same way.
  - Wrap mode: 0 -1 gives max; max +1 gives 0.
  - The cursor register updates at the same clk edge the tick is sampled on.
- Fire: a btn_c edge on a tick with enable=1 and sel_valid=0 sets sel_valid=1 and captures sel_row/sel_col from the cursor at that edge.
  - While sel_valid=1, moves and further fire edges are discarded, not queued.
  - Transfer completes at a clk edge where sel_valid&sel_ready; sel_valid reads 0 the following cycle.
  - sel_ready while sel_valid=0 has no effect.
  - enable falling does not cancel a pending selection.
- Display, combinational from hCount/vCount and the cursor registers:
  - Compute x0 = GRID_LEFT + col*CELL_W + LINE_THICK and y0 = GRID_TOP + row*CELL_H + LINE_THICK in 12-bit arithmetic.
  - in_cursor = bright && x0 <= hCount < x0 + CELL_W - 2*LINE_THICK && the equivalent condition for y.
  - hCount/vCount are zero-extended before comparison.

Optional Feature:
- Macro: CURSOR_AUTOREPEAT_EN.
- Defined: each direction keeps a hold counter, counting ticks while its debounced level is 1 and cleared when it is 0.
  - A step is generated on the edge, and again when the count equals REPEAT_DELAY.
  - After that, a step is generated every REPEAT_RATE ticks.
  - Repeat steps follow the same clamp/wrap, enable and sel_valid gating as edge steps.
  - btn_c never repeats.
- Undefined: only edges cause steps, and no hold counters are synthesised.

Decomposition:
- Package grid_pkg: grid and cell geometry defaults, a button index enum {BTN_L, BTN_R, BTN_U, BTN_D, BTN_C}, and RW/CW width helpers.
- Sub-module btn_debounce (params DEB_DEPTH): inputs clk, rst_n, tick, raw; outputs level, rise. Instantiated five times.

Test Plan:
All scenarios use SAMPLE_DIV=4, DEB_DEPTH=3.
1. Reset asserted mid-run -> cursor (0,0), sel_valid=0, in_cursor=0 for every pixel outside cell (0,0).
2. btn_r held 4 ticks -> cursor_col 0->1 exactly once. btn_r pattern 1,0,1,0 per tick -> no move.
3. WRAP=0: at col 9 press r -> stays 9. WRAP=1: at col 9 press r -> 0; at row 0 press u -> 9. l+r together -> no move.
4. At (3,4) press c -> sel_valid=1, sel_row=3, sel_col=4. Hold sel_ready=0 for 20 cycles and press d -> sel_valid stays 1, cursor unchanged. One-cycle sel_ready pulse -> sel_valid=0 next cycle.
5. Cursor (row 2, col 1), bright=1:
   - hCount=209, vCount=132 -> in_cursor 1.
   - hCount=208 -> 0; hCount=270 -> 1; hCount=271 -> 0.
   - vCount=177 -> 1; vCount=178 -> 0.
   - bright=0 -> 0.
6. With macro, REPEAT_DELAY=4, REPEAT_RATE=2: hold d for 8 ticks after the rising edge -> 3 row steps. Without macro -> 1 step. enable=0 -> 0 steps.

Source files
------------

// File: rtl/grid_pkg.sv
// Shared geometry defaults, button indices and index-width helpers for the grid cursor controller.
package grid_pkg;

   localparam int DEF_GRID_COLS  = 10;
   localparam int DEF_GRID_ROWS  = 10;
   localparam int DEF_CELL_W     = 64;
   localparam int DEF_CELL_H     = 48;
   localparam int DEF_GRID_LEFT  = 144;
   localparam int DEF_GRID_TOP   = 35;
   localparam int DEF_LINE_THICK = 1;

   localparam int NUM_BTN = 5;

   typedef enum logic [2:0] {BTN_L, BTN_R, BTN_U, BTN_D, BTN_C} btn_e;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int row_w(input int rows);
      return idx_w(rows);
   endfunction

   function automatic int col_w(input int cols);
      return idx_w(cols);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-button debouncer: DEB_DEPTH-sample history with hysteresis, plus a rising-edge flag
// that stays high from the tick the level rises until the next tick.
module btn_debounce #(
   parameter int DEB_DEPTH = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick,
   input  logic raw,
   output logic level,
   output logic rise
);

   logic [DEB_DEPTH-1:0] hist_q, hist_d;
   logic                 level_q, level_d;
   logic                 prev_q;

   always_comb begin
      hist_d  = hist_q;
      level_d = level_q;
      if (tick) begin
         hist_d = DEB_DEPTH'({hist_q, raw});
         if (&hist_d) begin
            level_d = 1'b1;
         end else if (~|hist_d) begin
            level_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hist_q  <= '0;
         level_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         hist_q  <= hist_d;
         level_q <= level_d;
         if (tick) begin
            prev_q <= level_q;
         end
      end
   end

   assign level = level_q;
   assign rise  = level_q & ~prev_q;

endmodule

// File: rtl/grid_cursor_ctrl.sv
// Battleship cursor: debounced buttons move a cursor over the grid, fire hands the cell to game
// logic on valid/ready, and the cursor cell is flagged for the renderer. CURSOR_AUTOREPEAT_EN adds held-button repeat.
module grid_cursor_ctrl
   import grid_pkg::*;
#(
   parameter int GRID_COLS  = DEF_GRID_COLS,
   parameter int GRID_ROWS  = DEF_GRID_ROWS,
   parameter int CELL_W     = DEF_CELL_W,
   parameter int CELL_H     = DEF_CELL_H,
   parameter int GRID_LEFT  = DEF_GRID_LEFT,
   parameter int GRID_TOP   = DEF_GRID_TOP,
   parameter int LINE_THICK = DEF_LINE_THICK,
   parameter int SAMPLE_DIV = 65536,
   parameter int DEB_DEPTH  = 3,
   parameter int WRAP       = 0
`ifdef CURSOR_AUTOREPEAT_EN
   ,
   parameter int REPEAT_DELAY = 24,
   parameter int REPEAT_RATE  = 6
`endif
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           bright,
   input  logic [9:0]                     hCount,
   input  logic [9:0]                     vCount,
   input  logic                           btn_l,
   input  logic                           btn_r,
   input  logic                           btn_u,
   input  logic                           btn_d,
   input  logic                           btn_c,
   input  logic                           enable,
   input  logic                           sel_ready,
   output logic                           sel_valid,
   output logic [row_w(GRID_ROWS)-1:0]    sel_row,
   output logic [col_w(GRID_COLS)-1:0]    sel_col,
   output logic [row_w(GRID_ROWS)-1:0]    cursor_row,
   output logic [col_w(GRID_COLS)-1:0]    cursor_col,
   output logic                           in_cursor
);

   localparam int RW = row_w(GRID_ROWS);
   localparam int CW = col_w(GRID_COLS);
   localparam int SW = idx_w(SAMPLE_DIV);

   logic [SW-1:0]      smp_cnt_q, smp_cnt_d;
   logic               tick;
   logic [NUM_BTN-1:0] raw, level, rise, step;
   logic [RW-1:0]      row_q, row_d, sel_row_q, sel_row_d;
   logic [CW-1:0]      col_q, col_d, sel_col_q, sel_col_d;
   logic               sel_valid_q, sel_valid_d;
   logic [11:0]        x0, x1, y0, y1, hc, vc;

   assign tick      = (smp_cnt_q == '0);
   assign smp_cnt_d = (smp_cnt_q == SW'(SAMPLE_DIV - 1)) ? '0 : smp_cnt_q + 1'b1;

   assign raw = {btn_c, btn_d, btn_u, btn_r, btn_l};

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_deb
      btn_debounce #(.DEB_DEPTH(DEB_DEPTH)) u_deb (
         .clk   (clk),
         .rst_n (rst_n),
         .tick  (tick),
         .raw   (raw[i]),
         .level (level[i]),
         .rise  (rise[i])
      );
   end

`ifdef CURSOR_AUTOREPEAT_EN
   localparam int HW = idx_w(REPEAT_DELAY + REPEAT_RATE + 1);

   logic [3:0][HW-1:0] hold_q, hold_d;
   logic [3:0]         rpt;

   // Once past the delay the count cycles over (DELAY, DELAY+RATE] so it never needs to saturate.
   always_comb begin
      hold_d = hold_q;
      rpt    = '0;
      for (int i = 0; i < 4; i++) begin
         rpt[i] = level[i] && ((hold_q[i] == HW'(REPEAT_DELAY)) ||
                               (hold_q[i] == HW'(REPEAT_DELAY + REPEAT_RATE)));
         if (tick) begin
            if (!level[i]) begin
               hold_d[i] = '0;
            end else if (hold_q[i] == HW'(REPEAT_DELAY + REPEAT_RATE)) begin
               hold_d[i] = HW'(REPEAT_DELAY + 1);
            end else begin
               hold_d[i] = hold_q[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hold_q <= '0;
      end else begin
         hold_q <= hold_d;
      end
   end

   assign step = (rise & level) | {1'b0, rpt};
`else
   assign step = rise & level;
`endif

   function automatic int axis_next(input int cur, input logic inc, input logic dec, input int top);
      int nxt;
      nxt = cur;
      if (inc && !dec) begin
         nxt = (cur == top) ? ((WRAP != 0) ? 0 : cur) : cur + 1;
      end else if (dec && !inc) begin
         nxt = (cur == 0) ? ((WRAP != 0) ? top : cur) : cur - 1;
      end
      return nxt;
   endfunction

   always_comb begin
      row_d       = row_q;
      col_d       = col_q;
      sel_row_d   = sel_row_q;
      sel_col_d   = sel_col_q;
      sel_valid_d = sel_valid_q;
      if (sel_valid_q && sel_ready) begin
         sel_valid_d = 1'b0;
      end
      if (tick && enable && !sel_valid_q) begin
         col_d = CW'(axis_next(int'(col_q), step[BTN_R], step[BTN_L], GRID_COLS - 1));
         row_d = RW'(axis_next(int'(row_q), step[BTN_D], step[BTN_U], GRID_ROWS - 1));
         if (step[BTN_C]) begin
            sel_valid_d = 1'b1;
            sel_row_d   = row_q;
            sel_col_d   = col_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         smp_cnt_q   <= '0;
         row_q       <= '0;
         col_q       <= '0;
         sel_row_q   <= '0;
         sel_col_q   <= '0;
         sel_valid_q <= 1'b0;
      end else begin
         smp_cnt_q   <= smp_cnt_d;
         row_q       <= row_d;
         col_q       <= col_d;
         sel_row_q   <= sel_row_d;
         sel_col_q   <= sel_col_d;
         sel_valid_q <= sel_valid_d;
      end
   end

   // Cursor rectangle sits inside the grid lines of its cell.
   always_comb begin
      x0 = 12'(GRID_LEFT) + 12'(col_q) * 12'(CELL_W) + 12'(LINE_THICK);
      y0 = 12'(GRID_TOP) + 12'(row_q) * 12'(CELL_H) + 12'(LINE_THICK);
      x1 = x0 + 12'(CELL_W - 2 * LINE_THICK);
      y1 = y0 + 12'(CELL_H - 2 * LINE_THICK);
      hc = {2'b00, hCount};
      vc = {2'b00, vCount};
   end

   assign in_cursor  = bright && (hc >= x0) && (hc < x1) && (vc >= y0) && (vc < y1);
   assign sel_valid  = sel_valid_q;
   assign sel_row    = sel_row_q;
   assign sel_col    = sel_col_q;
   assign cursor_row = row_q;
   assign cursor_col = col_q;

endmodule
